// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator with valid padding.
// Takes a raster-order pixel stream and keeps the last two image rows plus the
// current row in a shift register. For every accepted pixel p(r,c) with r>=2
// and c>=2, it registers the 3x3 window whose bottom-right corner is p(r,c).
// The output side is a single register stage with a valid/ready handshake.
module window_3x3_gen #(
   parameter int IMG_Width  = 224,
   parameter int IMG_Height = 224,
   parameter int Datawidth  = 8
) (
   input  logic                   CLK,
   input  logic                   CLR,
   input  logic                   Restart,
   input  logic                   In_Valid,
   output logic                   In_Ready,
   input  logic [Datawidth-1:0]   In_Data,
   output logic                   Out_Valid,
   input  logic                   Out_Ready,
   output logic [9*Datawidth-1:0] Win,
   output logic                   Frame_Done
);

   localparam int CW = $clog2(IMG_Width);
   localparam int RW = $clog2(IMG_Height);
   // The shift register holds 2W+2 older pixels. The incoming pixel supplies
   // the newest tap, so the window spans 2W+3 raster positions in total.
   localparam int DEPTH = 2 * IMG_Width + 2;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Height - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [CW-1:0]          col;
   logic [RW-1:0]          row;
   logic [Datawidth-1:0]   line_buf [DEPTH];
   logic                   accept;
   logic                   last_col;
   logic                   last_row;
   logic                   win_ok;
   logic [9*Datawidth-1:0] win_next;

   // The stage can take a new pixel when its output slot is empty or is
   // retiring this cycle. A frame abort blocks new pixels.
   assign In_Ready = (~Out_Valid | Out_Ready) & ~Restart;
   assign accept   = In_Valid & In_Ready;
   assign last_col = (col == COL_LAST);
   assign last_row = (row == ROW_LAST);
   // Windows touching the left or top border are never emitted. As a result,
   // taps that wrap across a row never reach the output.
   assign win_ok   = (row >= ROW_TWO) && (col >= COL_TWO);

   // The window is formed from the incoming pixel and the pre-shift storage.
   // line_buf[k] holds the pixel accepted k+1 positions before In_Data.
   // Tap 8 (bottom-right) is the MSB and tap 0 (top-left) is the LSB.
   assign win_next = {In_Data,                                  // p(r,  c)
                      line_buf[0],                              // p(r,  c-1)
                      line_buf[1],                              // p(r,  c-2)
                      line_buf[IMG_Width-1],                    // p(r-1,c)
                      line_buf[IMG_Width],                      // p(r-1,c-1)
                      line_buf[IMG_Width+1],                    // p(r-1,c-2)
                      line_buf[2*IMG_Width-1],                  // p(r-2,c)
                      line_buf[2*IMG_Width],                    // p(r-2,c-1)
                      line_buf[2*IMG_Width+1]};                 // p(r-2,c-2)

   // Pixel storage: shifts by one position on every accepted pixel.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         // NOTE: resetting every entry makes this storage flops rather than a
         // RAM. That cost is accepted because a cleared store is part of the
         // reset state.
         for (int i = 0; i < DEPTH; i++) line_buf[i] <= '0;
      end else if (accept) begin
         line_buf[0] <= In_Data;
         for (int i = 1; i < DEPTH; i++) line_buf[i] <= line_buf[i-1];
      end
   end

   // Raster position of the next pixel. A frame abort zeroes it.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         col <= '0;
         row <= '0;
      end else if (Restart) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Output register: loads on accept, holds under backpressure, and
   // empties when the current window retires and no new window arrives.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         Out_Valid  <= 1'b0;
         Win        <= '0;
         Frame_Done <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let the default below be overridden
         // later in the same block. The flop still sees only the last value.
         Frame_Done <= 1'b0;
         if (Restart) begin
            Out_Valid <= 1'b0;
         end else if (accept) begin
            Out_Valid  <= win_ok;
            Frame_Done <= last_col && last_row;
            if (win_ok) Win <= win_next;
         end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed self-checking bench for window_3x3_gen.
// Instance a is 4x4 (streaming, backpressure, CLR, Restart).
// Instance b is 5x4 (random gaps over three frames).
// Instance c uses the default 224x224 size (full ramp frame).
module tb_window_3x3_gen;

   logic CLK;
   logic CLR;

   logic        a_restart, a_in_valid, a_in_ready, a_ov, a_out_ready, a_fd;
   logic [7:0]  a_in_data;
   logic [71:0] a_win;
   logic        b_restart, b_in_valid, b_in_ready, b_ov, b_out_ready, b_fd;
   logic [7:0]  b_in_data;
   logic [71:0] b_win;
   logic        c_restart, c_in_valid, c_in_ready, c_ov, c_out_ready, c_fd;
   logic [7:0]  c_in_data;
   logic [71:0] c_win;

   int checks = 0;
   int errors = 0;

   localparam logic [71:0] FIRST_W = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
   localparam logic [71:0] LAST_W  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};

   window_3x3_gen #(.IMG_Width(4), .IMG_Height(4), .Datawidth(8)) dut_a (
      .CLK(CLK), .CLR(CLR), .Restart(a_restart), .In_Valid(a_in_valid), .In_Ready(a_in_ready),
      .In_Data(a_in_data), .Out_Valid(a_ov), .Out_Ready(a_out_ready), .Win(a_win),
      .Frame_Done(a_fd));

   window_3x3_gen #(.IMG_Width(5), .IMG_Height(4), .Datawidth(8)) dut_b (
      .CLK(CLK), .CLR(CLR), .Restart(b_restart), .In_Valid(b_in_valid), .In_Ready(b_in_ready),
      .In_Data(b_in_data), .Out_Valid(b_ov), .Out_Ready(b_out_ready), .Win(b_win),
      .Frame_Done(b_fd));

   window_3x3_gen dut_c (
      .CLK(CLK), .CLR(CLR), .Restart(c_restart), .In_Valid(c_in_valid), .In_Ready(c_in_ready),
      .In_Data(c_in_data), .Out_Valid(c_ov), .Out_Ready(c_out_ready), .Win(c_win),
      .Frame_Done(c_fd));

   // Free-running clock with a 10-unit period.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Expected window with bottom-right corner (r,c) for an image of width w.
   // The pixel at raster index idx has the value (off+idx) mod 256.
   function automatic logic [71:0] exp_win(input int w, input int r, input int c, input int off);
      logic [71:0] res;
      int idx;
      res = '0;
      for (int k = 0; k < 9; k++) begin
         idx = (r - 2 + k / 3) * w + (c - 2 + k % 3);
         res[k*8 +: 8] = 8'((off + idx) & 255);
      end
      return res;
   endfunction

   // Runs one cycle on instance a. Inputs are driven just after an edge and
   // the handshake is sampled before the next edge. The task returns one
   // time unit after that edge.
   task automatic a_cycle(input logic v, input logic [7:0] d, input logic ordy, input logic rs,
                          output logic acc, output logic ret, output logic [71:0] rwin);
      a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_restart = rs;
      #1;
      acc = v & a_in_ready;
      ret = a_ov & ordy;
      rwin = a_win;
      @(posedge CLK); #1;
   endtask

   // Runs one cycle on instance b, with the same timing as a_cycle.
   task automatic b_cycle(input logic v, input logic [7:0] d, input logic ordy,
                          output logic acc, output logic ret, output logic [71:0] rwin);
      b_in_valid = v; b_in_data = d; b_out_ready = ordy; b_restart = 1'b0;
      #1;
      acc = v & b_in_ready;
      ret = b_ov & ordy;
      rwin = b_win;
      @(posedge CLK); #1;
   endtask

   // Checks the outputs of all three instances while CLR is held low.
   task automatic test_reset();
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset a_ov: got %b want 0", a_ov); end
      checks++; if (a_win !== 72'd0) begin errors++; $display("FAIL reset a_win: got %h want 0", a_win); end
      checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL reset a_fd: got %b want 0", a_fd); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset a_in_ready: got %b want 1", a_in_ready); end
      checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL reset b_ov: got %b want 0", b_ov); end
      checks++; if (c_win !== 72'd0) begin errors++; $display("FAIL reset c_win: got %h want 0", c_win); end
   endtask

   // Feeds pixels 0..15 into instance a with Out_Ready held high and checks
   // the outputs after every edge.
   task automatic test_stream(input string tag);
      logic acc, ret, exp_ov;
      logic [71:0] rw;
      int r, c, nv;
      nv = 0;
      for (int i = 0; i < 16; i++) begin
         r = i / 4; c = i % 4;
         exp_ov = (r >= 2) && (c >= 2);
         a_cycle(1'b1, 8'(i), 1'b1, 1'b0, acc, ret, rw);
         nv += int'(a_ov);
         checks++; if (acc !== 1'b1) begin errors++; $display("FAIL stream[%s] accept px%0d: got %b want 1", tag, i, acc); end
         checks++; if (a_ov !== exp_ov) begin errors++; $display("FAIL stream[%s] out_valid px%0d: got %b want %b", tag, i, a_ov, exp_ov); end
         checks++; if (a_fd !== (i == 15)) begin errors++; $display("FAIL stream[%s] frame_done px%0d: got %b want %b", tag, i, a_fd, (i == 15)); end
         if (exp_ov) begin
            checks++; if (a_win !== exp_win(4, r, c, 0)) begin errors++; $display("FAIL stream[%s] win px%0d: got %h want %h", tag, i, a_win, exp_win(4, r, c, 0)); end
         end
         if (i == 10) begin
            checks++; if (a_win !== FIRST_W) begin errors++; $display("FAIL stream[%s] first window: got %h want %h", tag, a_win, FIRST_W); end
         end
         if (i == 15) begin
            checks++; if (a_win !== LAST_W) begin errors++; $display("FAIL stream[%s] last window: got %h want %h", tag, a_win, LAST_W); end
         end
      end
      a_cycle(1'b0, 8'd0, 1'b1, 1'b0, acc, ret, rw);
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL stream[%s] idle out_valid: got %b want 0", tag, a_ov); end
      checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL stream[%s] idle frame_done: got %b want 0", tag, a_fd); end
      checks++; if (nv !== 4) begin errors++; $display("FAIL stream[%s] window count: got %0d want 4", tag, nv); end
   endtask

   // Holds Out_Ready low for 5 cycles after the first window appears. The
   // held window and the overall window sequence must be unchanged.
   task automatic test_backpressure();
      logic acc, ret, seen, stalling;
      logic [71:0] rw, ew;
      int idx, nwin, stall, nfd, cyc;
      idx = 0; nwin = 0; stall = 0; nfd = 0; cyc = 0; seen = 1'b0;
      while ((idx < 16 || a_ov) && cyc < 80) begin
         stalling = seen && (stall < 5);
         a_cycle(idx < 16, 8'(idx), !stalling, 1'b0, acc, ret, rw);
         if (stalling) begin
            checks++; if (acc !== 1'b0) begin errors++; $display("FAIL bp in_ready stall%0d: got accept %b want 0", stall, acc); end
            checks++; if (a_ov !== 1'b1 || a_win !== FIRST_W) begin errors++; $display("FAIL bp hold stall%0d: got ov=%b win=%h want ov=1 win=%h", stall, a_ov, a_win, FIRST_W); end
            stall++;
         end
         if (ret) begin
            ew = exp_win(4, 2 + nwin / 2, 2 + nwin % 2, 0);
            checks++; if (nwin >= 4 || rw !== ew) begin errors++; $display("FAIL bp window%0d: got %h want %h", nwin, rw, ew); end
            nwin++;
         end
         if (acc) idx++;
         nfd += int'(a_fd);
         if (a_ov && !seen) begin
            seen = 1'b1;
            checks++; if (a_win !== FIRST_W) begin errors++; $display("FAIL bp first window: got %h want %h", a_win, FIRST_W); end
         end
         cyc++;
      end
      checks++; if (cyc >= 80) begin errors++; $display("FAIL bp timeout: got %0d cycles want <80", cyc); end
      checks++; if (nwin !== 4) begin errors++; $display("FAIL bp window count: got %0d want 4", nwin); end
      checks++; if (idx !== 16) begin errors++; $display("FAIL bp pixels accepted: got %0d want 16", idx); end
      checks++; if (nfd !== 1) begin errors++; $display("FAIL bp frame_done pulses: got %0d want 1", nfd); end
   endtask

   // Asserts CLR mid-frame while a window is valid. The reset must take
   // effect at once, and the next frame must start again from p(0,0).
   task automatic test_clr_mid();
      logic acc, ret;
      logic [71:0] rw;
      for (int i = 0; i <= 10; i++) a_cycle(1'b1, 8'(i), 1'b1, 1'b0, acc, ret, rw);
      checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL clr pre out_valid: got %b want 1", a_ov); end
      #2 CLR = 1'b0;
      #1;
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL clr async out_valid: got %b want 0", a_ov); end
      checks++; if (a_win !== 72'd0) begin errors++; $display("FAIL clr async win: got %h want 0", a_win); end
      @(posedge CLK); #1;
      CLR = 1'b1;
      test_stream("after_clr");
   endtask

   // Asserts Restart while pixel 11 is offered. Restart must win: the pixel
   // is refused and no window for p(2,3) appears.
   task automatic test_restart();
      logic acc, ret;
      logic [71:0] rw;
      for (int i = 0; i <= 10; i++) a_cycle(1'b1, 8'(i), 1'b1, 1'b0, acc, ret, rw);
      a_cycle(1'b1, 8'd11, 1'b1, 1'b1, acc, ret, rw);
      checks++; if (acc !== 1'b0) begin errors++; $display("FAIL restart accept px11: got %b want 0", acc); end
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL restart out_valid: got %b want 0", a_ov); end
      checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL restart frame_done: got %b want 0", a_fd); end
      a_cycle(1'b0, 8'd0, 1'b1, 1'b0, acc, ret, rw);
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL restart idle out_valid: got %b want 0", a_ov); end
      test_stream("after_restart");
   endtask

   // Runs three back-to-back 5x4 frames on instance b with random valid and
   // ready gaps, checked against a cycle model and a window queue.
   task automatic test_random_gaps();
      logic acc, ret, v, ordy, ov_m, fd_m, exp_acc;
      logic [71:0] rw, ew;
      logic [71:0] q[$];
      int f, r, c, total, nwin, nfd, cyc;
      f = 0; r = 0; c = 0; total = 0; nwin = 0; nfd = 0; cyc = 0; ov_m = 1'b0;
      while ((total < 60 || b_ov) && cyc < 3000) begin
         v = (total < 60) && ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         exp_acc = v & (~ov_m | ordy);
         b_cycle(v, 8'((f * 20 + r * 5 + c) & 255), ordy, acc, ret, rw);
         checks++; if (acc !== exp_acc) begin errors++; $display("FAIL rand accept cyc%0d: got %b want %b", cyc, acc, exp_acc); end
         if (ret) begin
            ew = (q.size() > 0) ? q.pop_front() : 72'd0;
            checks++; if (rw !== ew) begin errors++; $display("FAIL rand window%0d: got %h want %h", nwin, rw, ew); end
            nwin++;
         end
         fd_m = 1'b0;
         if (exp_acc) begin
            ov_m = (r >= 2) && (c >= 2);
            if (ov_m) q.push_back(exp_win(5, r, c, f * 20));
            if (c == 4) begin
               c = 0;
               if (r == 3) begin r = 0; f++; fd_m = 1'b1; end
               else r++;
            end else c++;
            total++;
         end else if (ordy) ov_m = 1'b0;
         checks++; if (b_ov !== ov_m) begin errors++; $display("FAIL rand out_valid cyc%0d: got %b want %b", cyc, b_ov, ov_m); end
         checks++; if (b_fd !== fd_m) begin errors++; $display("FAIL rand frame_done cyc%0d: got %b want %b", cyc, b_fd, fd_m); end
         nfd += int'(b_fd);
         cyc++;
      end
      checks++; if (cyc >= 3000) begin errors++; $display("FAIL rand timeout: got %0d cycles want <3000", cyc); end
      checks++; if (nwin !== 18) begin errors++; $display("FAIL rand window count: got %0d want 18", nwin); end
      checks++; if (nfd !== 3) begin errors++; $display("FAIL rand frame_done pulses: got %0d want 3", nfd); end
   endtask

   // Streams a full 224x224 ramp frame into instance c with no gaps.
   task automatic test_full_frame();
      int nwin, nfd, nbusy;
      nwin = 0; nfd = 0; nbusy = 0;
      for (int i = 0; i < 224 * 224; i++) begin
         c_in_valid = 1'b1; c_in_data = 8'(i & 255); c_out_ready = 1'b1; c_restart = 1'b0;
         #1;
         if (c_in_ready !== 1'b1) nbusy++;
         @(posedge CLK); #1;
         nwin += int'(c_ov);
         nfd += int'(c_fd);
         if (i == 2 * 224 + 2) begin
            checks++; if (c_win !== exp_win(224, 2, 2, 0)) begin errors++; $display("FAIL full first window: got %h want %h", c_win, exp_win(224, 2, 2, 0)); end
         end
      end
      checks++; if (c_fd !== 1'b1) begin errors++; $display("FAIL full frame_done: got %b want 1", c_fd); end
      checks++; if (c_win !== exp_win(224, 223, 223, 0)) begin errors++; $display("FAIL full last window: got %h want %h", c_win, exp_win(224, 223, 223, 0)); end
      checks++; if (c_win[71:64] !== 8'd255) begin errors++; $display("FAIL full last tap8: got %0d want 255", c_win[71:64]); end
      c_in_valid = 1'b0;
      @(posedge CLK); #1;
      checks++; if (c_ov !== 1'b0) begin errors++; $display("FAIL full idle out_valid: got %b want 0", c_ov); end
      checks++; if (nwin !== 222 * 222) begin errors++; $display("FAIL full window count: got %0d want %0d", nwin, 222 * 222); end
      checks++; if (nfd !== 1) begin errors++; $display("FAIL full frame_done pulses: got %0d want 1", nfd); end
      checks++; if (nbusy !== 0) begin errors++; $display("FAIL full in_ready drops: got %0d want 0", nbusy); end
   endtask

   initial begin
      CLR = 1'b0;
      a_restart = 1'b0; a_in_valid = 1'b0; a_in_data = 8'd0; a_out_ready = 1'b0;
      b_restart = 1'b0; b_in_valid = 1'b0; b_in_data = 8'd0; b_out_ready = 1'b0;
      c_restart = 1'b0; c_in_valid = 1'b0; c_in_data = 8'd0; c_out_ready = 1'b0;
      #7;
      test_reset();
      @(posedge CLK); #1;
      CLR = 1'b1;
      test_stream("basic");
      test_backpressure();
      test_clr_mid();
      test_restart();
      test_random_gaps();
      test_full_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
